// File: rtl/rv32m_muldiv_pkg.sv
// Shared RV32M multiply/divide definitions.
//   muldiv_funct3_t : funct3 encodings of the M extension
//   funct7_muldiv   : funct7 that routes an op_reg instruction to this unit
//   muldiv_state_t  : control states of the iterative unit
package rv32m_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_funct3_t;

  localparam logic [6:0] funct7_muldiv = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/rv32m_muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   is_div : 1 = restoring divide step, 0 = shift-add multiply step
//   b      : multiplicand (mul) or divisor (div), magnitude only
//   acc_hi : product high half / partial remainder
//   acc_lo : multiplier bits still to consume / dividend bits -> quotient
//   nxt_hi, nxt_lo : state after this iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  output logic [XLEN-1:0] nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Multiply: add b when the current multiplier bit is set, then shift the
  // whole {carry, hi, lo} right by one so the product grows into hi.
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : '0);

  // Divide: bring the next dividend bit into the partial remainder. The
  // remainder stays below the divisor, so after subtraction it fits XLEN bits.
  assign shifted = {acc_hi, acc_lo[XLEN-1]};
  assign ge      = shifted >= {1'b0, b};
  assign diff    = shifted[XLEN-1:0] - b;

  always_comb begin
    if (is_div) begin
      nxt_hi = ge ? diff : shifted[XLEN-1:0];
      nxt_lo = {acc_lo[XLEN-2:0], ge};
    end else begin
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, taken only while ready
//   funct3, rs1, rs2: operation and operands, sampled at accept
//   flush           : kill any in-flight operation (wins over start)
//   ready           : unit can accept this cycle (IDLE or DONE)
//   done            : one-cycle result-valid pulse
//   result          : held from done until the next result is produced
// Operands are converted to magnitudes at accept, iterated unsigned over
// XLEN/BITS_PER_CYCLE cycles, and sign-corrected in FIN.
module rv32m_muldiv
  import rv32m_muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t  state;
  muldiv_funct3_t op_q;
  muldiv_funct3_t f3_in;
  logic [2:0]      op_bits;
  logic            neg_q, rneg_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, result_q;
  logic [CW-1:0]   cnt_q;

  assign f3_in   = muldiv_funct3_t'(funct3);
  assign op_bits = op_q;

  // Accept-time operand conditioning
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, fast;

  assign sgn_a    = f3_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  assign sgn_b    = f3_in inside {MD_MULH, MD_DIV, MD_REM};
  assign neg_a    = sgn_a & rs1[XLEN-1];
  assign neg_b    = sgn_b & rs2[XLEN-1];
  assign abs_a    = neg_a ? -rs1 : rs1;
  assign abs_b    = neg_b ? -rs2 : rs2;
  assign div_zero = (rs2 == '0);
  // funct3[0] clear selects the signed div/rem
  assign div_ovf  = ~funct3[0] & (rs1 == INT_MIN) & (rs2 == '1);
  assign fast     = funct3[2] & (div_zero | div_ovf);

  // BITS_PER_CYCLE chained iterations per CALC cycle
  logic [BITS_PER_CYCLE:0][XLEN-1:0] hi_c, lo_c;
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_bits[2]),
      .b      (b_q),
      .acc_hi (hi_c[g]),
      .acc_lo (lo_c[g]),
      .nxt_hi (hi_c[g+1]),
      .nxt_lo (lo_c[g+1])
    );
  end

  // FIN: sign correction and result selection
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, remd, fin_res;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot     = neg_q ? -lo_q : lo_q;
  assign remd     = rneg_q ? -hi_q : hi_q;

  always_comb begin
    fin_res = remd;
    case (op_q)
      MD_MUL:                       fin_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fin_res = quot;
      default:                      fin_res = remd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q  <= f3_in;
            b_q   <= abs_b;
            cnt_q <= CW'(N - 1);
            if (fast) begin
              // Preload hi/lo so FIN's normal selection yields the
              // architectural answer with no sign fix-up.
              state  <= S_FIN;
              neg_q  <= 1'b0;
              rneg_q <= 1'b0;
              hi_q   <= div_zero ? rs1 : '0;
              lo_q   <= div_zero ? '1 : rs1;
            end else begin
              state  <= S_CALC;
              neg_q  <= neg_a ^ neg_b;
              rneg_q <= neg_a;
              hi_q   <= '0;
              lo_q   <= abs_a;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          hi_q  <= hi_c[BITS_PER_CYCLE];
          lo_q  <= lo_c[BITS_PER_CYCLE];
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state <= S_FIN;
        end
        S_FIN: begin
          result_q <= fin_res;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready  = (state == S_IDLE) | (state == S_DONE);
  assign done   = (state == S_DONE);
  assign result = result_q;

endmodule
